// File: rtl/apb_fsm_controller_pkg.sv
// Shared bridge definitions: APB sequencer states, default widths and the
// request decode used from IDLE and from a completing ACCESS phase.
package apb_fsm_controller_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NSEL_DEF   = 3;

  localparam logic [NSEL_DEF-1:0] SEL_NONE = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RENABLE = 3'd4,
    ST_WENABLE = 3'd5
  } state_t;

  // Where a pending AHB transfer sends the sequencer next.
  function automatic state_t req_decode(input logic req, input logic wr);
    if (!req)   return ST_IDLE;
    else if (wr) return ST_WWAIT;
    else        return ST_READ;
  endfunction

endpackage

// File: rtl/apb_fsm_controller_if.sv
// AHB pipeline inputs and APB bus outputs of the bridge sequencer.
// slave = the sequencer itself; master = upstream pipeline plus APB slave.
interface apb_fsm_controller_if
  import apb_fsm_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSEL   = NSEL_DEF
);
  logic              valid;
  logic              hwritereg;
  logic [ADDR_W-1:0] haddr1;
  logic [ADDR_W-1:0] haddr2;
  logic [DATA_W-1:0] hwdata1;
  logic [NSEL-1:0]   tempselx;
  logic              pready;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic [NSEL-1:0]   pselx;
  logic              penable;
  logic              hreadyout;

  modport slave (
    input  valid, hwritereg, haddr1, haddr2, hwdata1, tempselx, pready,
    output paddr, pwdata, pwrite, pselx, penable, hreadyout
  );

  modport master (
    output valid, hwritereg, haddr1, haddr2, hwdata1, tempselx, pready,
    input  paddr, pwdata, pwrite, pselx, penable, hreadyout
  );

endinterface

// File: rtl/apb_fsm_controller.sv
// APB3 sequencer of the AHB-to-APB bridge: one SETUP + ACCESS per AHB
// transfer, stalling the AHB master via hreadyout while APB is busy.
module apb_fsm_controller
  import apb_fsm_controller_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSEL   = NSEL_DEF
) (
  input  logic                  hclk,
  input  logic                  hreset,
  apb_fsm_controller_if.slave   bus
);

  state_t            state, state_nxt;
  logic              req;
  logic [NSEL-1:0]   sel_hold, sel_hold_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              pwrite_nxt;
  logic [NSEL-1:0]   pselx_nxt;
  logic              penable_nxt;

  // Unmapped transfers are dropped: they never reach the APB side.
  assign req = bus.valid && (bus.tempselx != NSEL'(SEL_NONE));

  always_ff @(posedge hclk) begin
    if (hreset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:                state_nxt = req_decode(req, bus.hwritereg);
      ST_WWAIT:               state_nxt = ST_WRITE;
      ST_READ:                state_nxt = ST_RENABLE;
      ST_WRITE:               state_nxt = ST_WENABLE;
      ST_RENABLE, ST_WENABLE: if (bus.pready) state_nxt = req_decode(req, bus.hwritereg);
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are loaded on entry to state_nxt; every self-loop is idempotent,
  // so decoding on state_nxt alone is enough.
  always_comb begin
    paddr_nxt    = bus.paddr;
    pwdata_nxt   = bus.pwdata;
    pwrite_nxt   = bus.pwrite;
    pselx_nxt    = bus.pselx;
    penable_nxt  = bus.penable;
    sel_hold_nxt = sel_hold;
    unique case (state_nxt)
      ST_IDLE: begin
        pselx_nxt   = NSEL'(SEL_NONE);
        penable_nxt = 1'b0;
      end
      ST_WWAIT: begin
        // Deselect so a back-to-back write never shows a stale SETUP.
        sel_hold_nxt = bus.tempselx;
        pselx_nxt    = NSEL'(SEL_NONE);
        penable_nxt  = 1'b0;
      end
      ST_READ: begin
        paddr_nxt    = bus.haddr1;
        pwrite_nxt   = 1'b0;
        pselx_nxt    = bus.tempselx;
        sel_hold_nxt = bus.tempselx;
        penable_nxt  = 1'b0;
      end
      ST_WRITE: begin
        paddr_nxt   = bus.haddr2;
        pwdata_nxt  = bus.hwdata1;
        pwrite_nxt  = 1'b1;
        pselx_nxt   = sel_hold;
        penable_nxt = 1'b0;
      end
      ST_RENABLE, ST_WENABLE: penable_nxt = 1'b1;
      default: begin
        pselx_nxt   = NSEL'(SEL_NONE);
        penable_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    unique case (state)
      ST_IDLE:                bus.hreadyout = 1'b1;
      ST_RENABLE, ST_WENABLE: bus.hreadyout = bus.pready;
      default:                bus.hreadyout = 1'b0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      bus.paddr   <= '0;
      bus.pwdata  <= '0;
      bus.pwrite  <= 1'b0;
      bus.pselx   <= '0;
      bus.penable <= 1'b0;
      sel_hold    <= '0;
    end else begin
      bus.paddr   <= paddr_nxt;
      bus.pwdata  <= pwdata_nxt;
      bus.pwrite  <= pwrite_nxt;
      bus.pselx   <= pselx_nxt;
      bus.penable <= penable_nxt;
      sel_hold    <= sel_hold_nxt;
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for the bridge APB sequencer: reset, read, write, wait
// states, back-to-back, unmapped and reset-abort scenarios.
module tb_apb_fsm_controller;

  logic hclk;
  logic hreset;
  int   checks;
  int   errors;

  apb_fsm_controller_if #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) bus ();

  apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Advance one edge; inputs written afterwards apply to the next edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid = 1'b0; bus.hwritereg = 1'b0; bus.tempselx = 3'b000;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    idle_inputs();
    bus.haddr1 = '0; bus.haddr2 = '0; bus.hwdata1 = '0; bus.pready = 1'b0;
    step(); step();
    hreset = 1'b0;
    #1;
    checks++; if (bus.paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 00000000", bus.paddr); end
    checks++; if (bus.pwdata !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h exp 00000000", bus.pwdata); end
    checks++; if ({bus.pwrite, bus.pselx, bus.penable} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 00000", {bus.pwrite, bus.pselx, bus.penable}); end
    checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL rst_hready got %b exp 1", bus.hreadyout); end
  endtask

  task automatic test_read();
    bus.valid = 1'b1; bus.hwritereg = 1'b0; bus.haddr1 = 32'h8000_0010; bus.tempselx = 3'b001; bus.pready = 1'b1;
    step();
    idle_inputs(); #1;
    checks++; if ({bus.pselx, bus.pwrite, bus.penable} !== 5'b001_0_0) begin errors++; $display("FAIL rd_setup_ctrl got %b exp 00100", {bus.pselx, bus.pwrite, bus.penable}); end
    checks++; if (bus.paddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_setup_paddr got %h exp 80000010", bus.paddr); end
    checks++; if (bus.hreadyout !== 1'b0) begin errors++; $display("FAIL rd_setup_hready got %b exp 0", bus.hreadyout); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b001_1_1) begin errors++; $display("FAIL rd_access got %b exp 00111", {bus.pselx, bus.penable, bus.hreadyout}); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL rd_idle got %b exp 00001", {bus.pselx, bus.penable, bus.hreadyout}); end
    checks++; if (bus.paddr !== 32'h8000_0010) begin errors++; $display("FAIL rd_idle_paddr got %h exp 80000010", bus.paddr); end
  endtask

  task automatic test_write();
    bus.valid = 1'b1; bus.hwritereg = 1'b1; bus.tempselx = 3'b010; bus.pready = 1'b1;
    bus.haddr1 = 32'h8400_0004; bus.haddr2 = 32'h8400_0004; bus.hwdata1 = 32'hDEAD_BEEF;
    step();
    idle_inputs(); #1;
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b000_0_0) begin errors++; $display("FAIL wr_wwait got %b exp 00000", {bus.pselx, bus.penable, bus.hreadyout}); end
    step();
    checks++; if ({bus.pselx, bus.pwrite, bus.penable, bus.hreadyout} !== 6'b010_1_0_0) begin errors++; $display("FAIL wr_setup_ctrl got %b exp 010100", {bus.pselx, bus.pwrite, bus.penable, bus.hreadyout}); end
    checks++; if (bus.paddr !== 32'h8400_0004) begin errors++; $display("FAIL wr_setup_paddr got %h exp 84000004", bus.paddr); end
    checks++; if (bus.pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_setup_pwdata got %h exp deadbeef", bus.pwdata); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b010_1_1) begin errors++; $display("FAIL wr_access got %b exp 01011", {bus.pselx, bus.penable, bus.hreadyout}); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout, bus.pwrite} !== 6'b000_0_1_1) begin errors++; $display("FAIL wr_idle got %b exp 000011", {bus.pselx, bus.penable, bus.hreadyout, bus.pwrite}); end
    checks++; if (bus.pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_idle_pwdata got %h exp deadbeef", bus.pwdata); end
  endtask

  task automatic test_wait_states();
    bus.valid = 1'b1; bus.hwritereg = 1'b0; bus.haddr1 = 32'h8800_0020; bus.tempselx = 3'b100; bus.pready = 1'b0;
    step();
    idle_inputs(); #1;
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b100_0_0) begin errors++; $display("FAIL ws_setup got %b exp 10000", {bus.pselx, bus.penable, bus.hreadyout}); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus.pselx, bus.pwrite, bus.penable, bus.hreadyout} !== 6'b100_0_1_0) begin errors++; $display("FAIL ws_stall%0d got %b exp 100010", i, {bus.pselx, bus.pwrite, bus.penable, bus.hreadyout}); end
      checks++; if (bus.paddr !== 32'h8800_0020) begin errors++; $display("FAIL ws_stall%0d_paddr got %h exp 88000020", i, bus.paddr); end
    end
    step();
    bus.pready = 1'b1; #1;
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b100_1_1) begin errors++; $display("FAIL ws_done got %b exp 10011", {bus.pselx, bus.penable, bus.hreadyout}); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL ws_idle got %b exp 00001", {bus.pselx, bus.penable, bus.hreadyout}); end
  endtask

  task automatic test_back_to_back();
    bus.valid = 1'b1; bus.hwritereg = 1'b1; bus.tempselx = 3'b010; bus.pready = 1'b1;
    bus.haddr1 = 32'h8400_0008; bus.haddr2 = 32'h8400_0008; bus.hwdata1 = 32'h1234_5678;
    step();
    idle_inputs();
    step(); step();
    // WENABLE completing while the next (read) transfer is already pending.
    bus.valid = 1'b1; bus.hwritereg = 1'b0; bus.haddr1 = 32'h8000_0100; bus.tempselx = 3'b001; #1;
    checks++; if ({bus.pselx, bus.pwrite, bus.penable, bus.hreadyout} !== 6'b010_1_1_1) begin errors++; $display("FAIL b2b_wacc got %b exp 010111", {bus.pselx, bus.pwrite, bus.penable, bus.hreadyout}); end
    step();
    idle_inputs(); #1;
    checks++; if ({bus.pselx, bus.pwrite, bus.penable, bus.hreadyout} !== 6'b001_0_0_0) begin errors++; $display("FAIL b2b_rsetup got %b exp 001000", {bus.pselx, bus.pwrite, bus.penable, bus.hreadyout}); end
    checks++; if (bus.paddr !== 32'h8000_0100) begin errors++; $display("FAIL b2b_paddr got %h exp 80000100", bus.paddr); end
    checks++; if (bus.pwdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_pwdata got %h exp 12345678", bus.pwdata); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b001_1_1) begin errors++; $display("FAIL b2b_racc got %b exp 00111", {bus.pselx, bus.penable, bus.hreadyout}); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL b2b_idle got %b exp 00001", {bus.pselx, bus.penable, bus.hreadyout}); end
  endtask

  task automatic test_unmapped();
    bus.valid = 1'b1; bus.hwritereg = 1'b0; bus.haddr1 = 32'h9000_0000; bus.tempselx = 3'b000; bus.pready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL unm%0d got %b exp 00001", i, {bus.pselx, bus.penable, bus.hreadyout}); end
      checks++; if (bus.paddr !== 32'h8000_0100) begin errors++; $display("FAIL unm%0d_paddr got %h exp 80000100", i, bus.paddr); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    bus.valid = 1'b1; bus.hwritereg = 1'b1; bus.tempselx = 3'b100; bus.pready = 1'b0;
    bus.haddr1 = 32'h8C00_0000; bus.haddr2 = 32'h8C00_0000; bus.hwdata1 = 32'hA5A5_A5A5;
    step();
    idle_inputs();
    step(); step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b100_1_0) begin errors++; $display("FAIL ab_wacc got %b exp 10010", {bus.pselx, bus.penable, bus.hreadyout}); end
    hreset = 1'b1;
    step();
    hreset = 1'b0; #1;
    checks++; if ({bus.pselx, bus.penable, bus.pwrite, bus.hreadyout} !== 6'b000_0_0_1) begin errors++; $display("FAIL ab_rst_ctrl got %b exp 000001", {bus.pselx, bus.penable, bus.pwrite, bus.hreadyout}); end
    checks++; if ({bus.paddr, bus.pwdata} !== 64'h0) begin errors++; $display("FAIL ab_rst_data got %h exp 0", {bus.paddr, bus.pwdata}); end
    step();
    checks++; if ({bus.pselx, bus.penable, bus.hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL ab_after got %b exp 00001", {bus.pselx, bus.penable, bus.hreadyout}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_back_to_back();
    test_unmapped();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

Sequences the APB side of the AHB-to-APB bridge. Consumes the registered AHB pipeline outputs of the bridge's AHB slave interface (valid, registered address/data/write, peripheral select) and drives one APB3 transfer per AHB transfer: a SETUP cycle, then ACCESS cycles until `pready`. It stalls the AHB master through `hreadyout` while an APB transfer is in flight.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `NSEL`, 3, number of one-hot peripheral selects
---
- `hclk`  in  1  bridge clock, all logic on rising edge
- `hreset`  in  1  synchronous, active-high reset
- `valid`  in  1  registered "AHB transfer pending" (htrans non-IDLE, one cycle late)
- `hwritereg`  in  1  registered hwrite, aligned with `valid`
- `haddr1`  in  ADDR_W  address aligned with `valid`
- `haddr2`  in  ADDR_W  `haddr1` delayed one cycle
- `hwdata1`  in  DATA_W  write data delayed one cycle
- `tempselx`  in  NSEL  registered one-hot select aligned with `valid`; 0 = unmapped
- `pready`  in  1  APB slave ready
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pwrite`  out  1  APB direction
- `pselx`  out  NSEL  APB one-hot select
- `penable`  out  1  APB enable
- `hreadyout`  out  1  AHB ready to master

## Operation
- States: IDLE, WWAIT, READ, WRITE, RENABLE, WENABLE.
- Define "req" = `valid` & (`tempselx` != 0). Unmapped transfers (`tempselx`=0) are dropped; FSM treats them as no request.
- IDLE: req & !`hwritereg` -> READ; req & `hwritereg` -> WWAIT; else IDLE.
- WWAIT (write data arriving): -> WRITE unconditionally.
- READ (SETUP): -> RENABLE.
- WRITE (SETUP): -> WENABLE.
- RENABLE/WENABLE (ACCESS): `pready`=0 -> stay; `pready`=1 -> same decode as IDLE (back-to-back without returning to IDLE).
- On entry to READ: `paddr`<=`haddr1`, `pwrite`<=0, `pselx`<=`tempselx`, `penable`<=0; selected values captured in a holding register.
- On entry to WWAIT: capture `tempselx` into holding register.
- On entry to WRITE: `paddr`<=`haddr2`, `pwdata`<=`hwdata1`, `pwrite`<=1, `pselx`<=held select, `penable`<=0.
- On entry to RENABLE/WENABLE: `penable`<=1; `paddr`, `pwdata`, `pwrite`, `pselx` unchanged.
- On entry to IDLE: `pselx`<=0, `penable`<=0; `paddr`, `pwdata`, `pwrite` hold last value.
- `pwdata` changes only on entry to WRITE.
- `hreadyout` (combinational from state): 1 in IDLE; `pready` in RENABLE/WENABLE; 0 in WWAIT, READ, WRITE.
- Upstream holds AHB address/data while `hreadyout`=0, so `haddr1`/`haddr2`/`hwdata1` stay valid during stalls.

## Timing
- Reset (sync, `hreset`=1 at a rising edge): state IDLE, `paddr`=0, `pwdata`=0, `pwrite`=0, `pselx`=0, `penable`=0; `hreadyout`=1 next cycle.
- Reset mid-transfer aborts it; no completion is signalled.
- All APB outputs registered; `hreadyout` is the only combinational output.
- Read: `valid` seen in IDLE at cycle N -> SETUP at N+1 -> ACCESS at N+2; with `pready`=1 the read completes at N+2 (`hreadyout`=1).
- Write: `valid` at N -> WWAIT at N+1 -> SETUP at N+2 -> ACCESS at N+3; completes at N+3 with `pready`=1.
- Each `pready`=0 cycle adds one ACCESS cycle; outputs stable throughout.
- Back-to-back: ACCESS completing with req -> next SETUP (read) or WWAIT (write) on next edge; `penable` drops to 0 that cycle.
- `penable`=1 only in the cycle immediately following SETUP, or in the stall cycles extending it.

## Structure
- Shared bridge package: state enum (6 states, 3-bit encoding), `ADDR_W`/`DATA_W`/`NSEL` defaults, `SEL_NONE`=0.
- Single module, no sub-modules: one next-state block, one registered output block.

## Test plan
- Reset: assert `hreset` mid-WENABLE with `pready`=0 -> next cycle IDLE, `pselx`=0, `penable`=0, `paddr`=0, `hreadyout`=1.
- Single read, `haddr1`=0x8000_0010, `tempselx`=001, `pready`=1 -> SETUP `pselx`=001 `pwrite`=0 `paddr`=0x8000_0010, then `penable`=1, `hreadyout`=1; back to IDLE.
- Single write, addr 0x8400_0004, data 0xDEAD_BEEF, `tempselx`=010 -> WWAIT, SETUP `paddr`=0x8400_0004 `pwdata`=0xDEAD_BEEF `pwrite`=1, ACCESS; total 3 cycles after `valid`.
- Wait states: read with `pready` low 3 cycles -> 4 ACCESS cycles, outputs stable, `hreadyout`=0 until `pready`=1.
- Back-to-back write then read (`valid` high in WENABLE completion) -> direct WENABLE->READ, `penable` 1->0, no IDLE cycle.
- Unmapped: `valid`=1, `tempselx`=000 -> stays IDLE, `pselx`=0, `hreadyout`=1.
